// File: rtl/fetch_ir_pkg.sv
// rtl/fetch_ir_pkg.sv - shared types and constants for the fetch/IR stage and control unit
package fetch_ir_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DROP  = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_INC   = 2'd0,
    PC_SEL_REDIR = 2'd1,
    PC_SEL_TGT   = 2'd2
  } pc_sel_e;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_ir_if.sv
// rtl/fetch_ir_if.sv - instruction memory and decode-side signals of the fetch stage
interface fetch_ir_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [24:0] inm;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic        redir;
  logic [31:0] redir_pc;

  modport master (
    output mem_req, mem_addr, instr_valid, instr, inm, opcode, pc_out,
    input  mem_ack, mem_rdata, instr_ready, redir, redir_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, inm, opcode, pc_out,
    output mem_ack, mem_rdata, instr_ready, redir, redir_pc
  );
endinterface

// File: rtl/fetch_ir_reg_pc.sv
// rtl/fetch_ir_reg_pc.sv - program counter with next-PC select (increment, redirect, stored target)
module reg_pc
  import fetch_ir_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  pc_sel_e     i_sel,
  input  logic [31:0] i_redir_pc,
  input  logic [31:0] i_tgt_pc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;

  always_comb begin
    w_pc_nx = r_pc + 32'd4;
    unique case (i_sel)
      PC_SEL_REDIR: w_pc_nx = word_align(i_redir_pc);
      PC_SEL_TGT:   w_pc_nx = i_tgt_pc;
      default:      w_pc_nx = r_pc + 32'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= w_pc_nx;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ir.sv
// rtl/fetch_ir.sv - instruction fetch and instruction register stage
module fetch_ir
  import fetch_ir_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_ir_if.master    bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nx;
  logic [31:0]  r_ir;
  logic [31:0]  r_pc_out;
  logic [31:0]  r_tgt;
  logic [31:0]  w_pc;
  logic         w_pc_load;
  pc_sel_e      w_pc_sel;
  logic         w_ir_load;
  logic         w_tgt_load;

  reg_pc #(.RESET_PC(RESET_PC)) u_reg_pc (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_pc_load),
    .i_sel      (w_pc_sel),
    .i_redir_pc (bus.redir_pc),
    .i_tgt_pc   (r_tgt),
    .o_pc       (w_pc)
  );

  // Redirect outranks ack and consume; in DROP a same-cycle redirect is the newest target
  always_comb begin
    w_state_nx = r_state;
    w_pc_load  = 1'b0;
    w_pc_sel   = PC_SEL_INC;
    w_ir_load  = 1'b0;
    w_tgt_load = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if (bus.redir) begin
          if (bus.mem_ack) begin
            w_pc_load = 1'b1;
            w_pc_sel  = PC_SEL_REDIR;
          end else begin
            w_tgt_load = 1'b1;
            w_state_nx = ST_DROP;
          end
        end else if (bus.mem_ack) begin
          w_ir_load  = 1'b1;
          w_state_nx = ST_VALID;
        end
      end
      ST_DROP: begin
        w_tgt_load = bus.redir;
        if (bus.mem_ack) begin
          w_pc_load  = 1'b1;
          w_pc_sel   = bus.redir ? PC_SEL_REDIR : PC_SEL_TGT;
          w_state_nx = ST_FETCH;
        end
      end
      ST_VALID: begin
        if (bus.redir) begin
          w_pc_load  = 1'b1;
          w_pc_sel   = PC_SEL_REDIR;
          w_state_nx = ST_FETCH;
        end else if (bus.instr_ready) begin
          w_pc_load  = 1'b1;
          w_pc_sel   = PC_SEL_INC;
          w_state_nx = ST_FETCH;
        end
      end
      default: w_state_nx = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_FETCH;
      r_ir     <= NOP;
      r_pc_out <= RESET_PC;
      r_tgt    <= RESET_PC;
    end else begin
      r_state <= w_state_nx;
      if (w_ir_load) begin
        r_ir     <= bus.mem_rdata;
        r_pc_out <= w_pc;
      end
      if (w_tgt_load) begin
        r_tgt <= word_align(bus.redir_pc);
      end
    end
  end

  assign bus.mem_req     = (r_state == ST_FETCH) || (r_state == ST_DROP);
  assign bus.mem_addr    = w_pc;
  assign bus.instr_valid = (r_state == ST_VALID);
  assign bus.instr       = r_ir;
  assign bus.inm         = r_ir[31:7];
  assign bus.opcode      = r_ir[6:0];
  assign bus.pc_out      = r_pc_out;

endmodule
